// File: rtl/seg7_scan_driver_pkg.sv
// ----------------------------------------------------------------------------
// seg7_scan_driver_pkg
// Shared constants for the seven-segment scan driver. The constants cover the
// digit count, the active-low segment codes (bit order {g,f,e,d,c,b,a}) for
// hex digits 0..F, and the "all dark" patterns for segments and anodes.
// No ports (package).
// ----------------------------------------------------------------------------
package seg7_scan_driver_pkg;

    localparam int unsigned NUM_DIGITS = 8;

    // Active-low segment codes, {g,f,e,d,c,b,a}
    localparam logic [6:0] SEG_HEX_0 = 7'h40;
    localparam logic [6:0] SEG_HEX_1 = 7'h79;
    localparam logic [6:0] SEG_HEX_2 = 7'h24;
    localparam logic [6:0] SEG_HEX_3 = 7'h30;
    localparam logic [6:0] SEG_HEX_4 = 7'h19;
    localparam logic [6:0] SEG_HEX_5 = 7'h12;
    localparam logic [6:0] SEG_HEX_6 = 7'h02;
    localparam logic [6:0] SEG_HEX_7 = 7'h78;
    localparam logic [6:0] SEG_HEX_8 = 7'h00;
    localparam logic [6:0] SEG_HEX_9 = 7'h10;
    localparam logic [6:0] SEG_HEX_A = 7'h08;
    localparam logic [6:0] SEG_HEX_B = 7'h03;
    localparam logic [6:0] SEG_HEX_C = 7'h46;
    localparam logic [6:0] SEG_HEX_D = 7'h21;
    localparam logic [6:0] SEG_HEX_E = 7'h06;
    localparam logic [6:0] SEG_HEX_F = 7'h0E;

    localparam logic [6:0] SEG_OFF = 7'h7F;
    localparam logic [7:0] AN_OFF  = 8'hFF;

endpackage : seg7_scan_driver_pkg

// File: rtl/seg7_scan_driver_hex_to_seg7.sv
// ----------------------------------------------------------------------------
// hex_to_seg7
// Purely combinational hex nibble to seven-segment decoder (active-low).
// Ports:
//   i_nibble [3:0] : hex digit to decode
//   o_seg    [6:0] : segment pattern {g,f,e,d,c,b,a}, 0 = segment lit
// ----------------------------------------------------------------------------
module hex_to_seg7
    import seg7_scan_driver_pkg::*;
(
    input  logic [3:0] i_nibble,
    output logic [6:0] o_seg
);

    always_comb begin
        o_seg = SEG_OFF;
        case (i_nibble)
            4'h0: o_seg = SEG_HEX_0;
            4'h1: o_seg = SEG_HEX_1;
            4'h2: o_seg = SEG_HEX_2;
            4'h3: o_seg = SEG_HEX_3;
            4'h4: o_seg = SEG_HEX_4;
            4'h5: o_seg = SEG_HEX_5;
            4'h6: o_seg = SEG_HEX_6;
            4'h7: o_seg = SEG_HEX_7;
            4'h8: o_seg = SEG_HEX_8;
            4'h9: o_seg = SEG_HEX_9;
            4'hA: o_seg = SEG_HEX_A;
            4'hB: o_seg = SEG_HEX_B;
            4'hC: o_seg = SEG_HEX_C;
            4'hD: o_seg = SEG_HEX_D;
            4'hE: o_seg = SEG_HEX_E;
            4'hF: o_seg = SEG_HEX_F;
            default: o_seg = SEG_OFF;
        endcase
    end

endmodule : hex_to_seg7

// File: rtl/seg7_scan_driver.sv
// ----------------------------------------------------------------------------
// seg7_scan_driver
// Time-multiplexed driver for an 8-digit common-anode seven-segment display.
// Scans one digit per CLK_DIV-cycle slot, darkens the first BLANK_CYCLES of
// every slot against ghosting, snapshots the inputs once per frame so a frame
// never tears, and optionally blanks leading zeros (digit 0 always shows).
// Parameters:
//   CLK_DIV      : io_clk cycles per digit slot (>= 2)
//   BLANK_CYCLES : dark cycles at the start of each slot (< CLK_DIV)
// Ports:
//   io_clk     : clock, rising edge
//   clrn       : asynchronous active-low reset
//   value      : 32-bit word, nibble i -> digit i (digit 0 rightmost)
//   dp_mask    : bit i = 1 lights decimal point of digit i
//   blank_lz   : 1 enables leading-zero blanking
//   enable     : 0 forces all anodes off (scan keeps running)
//   an         : anode selects, active-low
//   seg        : segments {g,f,e,d,c,b,a}, active-low
//   dp         : decimal point, active-low
//   frame_tick : one-cycle pulse after each snapshot load
// ----------------------------------------------------------------------------
module seg7_scan_driver
    import seg7_scan_driver_pkg::*;
#(
    parameter int unsigned CLK_DIV      = 50000,
    parameter int unsigned BLANK_CYCLES = 2
)
(
    input  logic        io_clk,
    input  logic        clrn,
    input  logic [31:0] value,
    input  logic [7:0]  dp_mask,
    input  logic        blank_lz,
    input  logic        enable,
    output logic [7:0]  an,
    output logic [6:0]  seg,
    output logic        dp,
    output logic        frame_tick
);

    localparam int unsigned    PW     = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [PW-1:0]  P_LAST = PW'(CLK_DIV - 1);
    localparam int unsigned    DW     = $clog2(NUM_DIGITS);
    localparam logic [DW-1:0]  D_LAST = DW'(NUM_DIGITS - 1);

    logic [PW-1:0] r_p;
    logic [DW-1:0] r_d;
    logic [31:0]   r_snap_val;
    logic [7:0]    r_snap_dp;
    logic          r_snap_lz;

    logic          w_slot_end;
    logic          w_frame_end;
    logic [4:0]    w_bit_ofs;
    logic [3:0]    w_nibble;
    logic          w_upper_zero;
    logic          w_lz_blank;
    logic          w_past_blank;
    logic          w_lit;
    logic [6:0]    w_seg;

    assign w_slot_end  = (r_p == P_LAST);
    assign w_frame_end = w_slot_end && (r_d == D_LAST);

    assign w_bit_ofs = {r_d, 2'b00};
    assign w_nibble  = r_snap_val[w_bit_ofs +: 4];

    // Shifting the current digit down to bit 0 leaves exactly nibbles d..7;
    // if that remainder is zero, this digit is a leading zero.
    assign w_upper_zero = ((r_snap_val >> w_bit_ofs) == '0);
    assign w_lz_blank   = r_snap_lz && (r_d != '0) && w_upper_zero;

    assign w_past_blank = (32'(r_p) >= BLANK_CYCLES);
    assign w_lit        = enable && w_past_blank && !w_lz_blank;

    hex_to_seg7 u_hex_to_seg7 (
        .i_nibble (w_nibble),
        .o_seg    (w_seg)
    );

    // Slot prescaler and digit index; keep running regardless of enable.
    always_ff @(posedge io_clk or negedge clrn) begin
        if (!clrn) begin
            r_p <= '0;
            r_d <= '0;
        end else if (w_slot_end) begin
            r_p <= '0;
            r_d <= (r_d == D_LAST) ? '0 : r_d + DW'(1);
        end else begin
            r_p <= r_p + PW'(1);
        end
    end

    // Frame snapshot: inputs are only observed on the last cycle of digit 7.
    always_ff @(posedge io_clk or negedge clrn) begin
        if (!clrn) begin
            r_snap_val <= '0;
            r_snap_dp  <= '0;
            r_snap_lz  <= 1'b0;
        end else if (w_frame_end) begin
            r_snap_val <= value;
            r_snap_dp  <= dp_mask;
            r_snap_lz  <= blank_lz;
        end
    end

    // Registered outputs, one cycle behind (r_p, r_d).
    always_ff @(posedge io_clk or negedge clrn) begin
        if (!clrn) begin
            an         <= AN_OFF;
            seg        <= SEG_OFF;
            dp         <= 1'b1;
            frame_tick <= 1'b0;
        end else begin
            frame_tick <= w_frame_end;
            if (w_lit) begin
                an  <= ~(8'b1 << r_d);
                seg <= w_seg;
                dp  <= ~r_snap_dp[r_d];
            end else begin
                an  <= AN_OFF;
                seg <= SEG_OFF;
                dp  <= 1'b1;
            end
        end
    end

endmodule : seg7_scan_driver

// File: tb/tb_seg7_scan_driver.sv
// ----------------------------------------------------------------------------
// tb_seg7_scan_driver
// Directed, table-driven bench for seg7_scan_driver with CLK_DIV = 4 and
// BLANK_CYCLES = 1. Each table record describes one frame: the inputs applied
// at its start (sampled at its end) and the hand-computed per-digit display
// expected during it (from the previous frame's snapshot).
// ----------------------------------------------------------------------------
module tb_seg7_scan_driver;

    localparam int unsigned CLK_DIV      = 4;
    localparam int unsigned BLANK_CYCLES = 1;

    localparam logic [63:0] AN_NORM = 64'h7FBFDFEF_F7FBFDFE;
    localparam logic [63:0] AN_DARK = 64'hFFFFFFFF_FFFFFFFF;
    localparam logic [63:0] SEG_ALL0 = 64'h40404040_40404040;
    localparam logic [63:0] SEG_ALL1 = 64'h79797979_79797979;
    localparam logic [63:0] SEG_ALL2 = 64'h24242424_24242424;
    localparam logic [63:0] SEG_ALL3 = 64'h30303030_30303030;
    localparam logic [63:0] SEG_DARK = 64'h7F7F7F7F_7F7F7F7F;

    logic        io_clk = 1'b0;
    logic        clrn = 1'b1;
    logic [31:0] value = '0;
    logic [7:0]  dp_mask = '0;
    logic        blank_lz = 1'b0;
    logic        enable = 1'b1;
    logic [7:0]  an;
    logic [6:0]  seg;
    logic        dp;
    logic        frame_tick;

    int n_checks = 0;
    int n_errors = 0;

    seg7_scan_driver #(
        .CLK_DIV      (CLK_DIV),
        .BLANK_CYCLES (BLANK_CYCLES)
    ) dut (
        .io_clk     (io_clk),
        .clrn       (clrn),
        .value      (value),
        .dp_mask    (dp_mask),
        .blank_lz   (blank_lz),
        .enable     (enable),
        .an         (an),
        .seg        (seg),
        .dp         (dp),
        .frame_tick (frame_tick)
    );

    always #5 io_clk = ~io_clk;

    typedef struct {
        logic [31:0] value;
        logic [7:0]  dpm;
        logic        lz;
        logic        en;
        int          chg_slot;   // slot at which value switches to chg_val (8 = never)
        logic [31:0] chg_val;
        int          abort_slot; // stop checking at this slot (8 = full frame)
        logic [63:0] an_exp;     // byte s = anodes while digit s lit
        logic [63:0] seg_exp;    // byte s (low 7 bits) = segments for digit s
        logic [7:0]  dp_exp;     // bit s = dp for digit s
    } frame_t;

    frame_t tbl [11];

    task automatic check(input string name, input logic [16:0] act, input logic [16:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got an=%h seg=%h dp=%b tick=%b, expected an=%h seg=%h dp=%b tick=%b",
                     name, act[16:9], act[8:2], act[1], act[0], exp[16:9], exp[8:2], exp[1], exp[0]);
        end
    endtask

    task automatic tick();
        @(posedge io_clk);
        #1;
    endtask

    task automatic run_frame(input int idx);
        frame_t r;
        logic [16:0] exp;
        logic        t_exp;
        r = tbl[idx];
        value    = r.value;
        dp_mask  = r.dpm;
        blank_lz = r.lz;
        enable   = r.en;
        for (int s = 0; s < 8; s++) begin
            if (s == r.abort_slot) return;
            if (s == r.chg_slot) value = r.chg_val;
            for (int p = 0; p < int'(CLK_DIV); p++) begin
                tick();
                t_exp = (s == 7) && (p == int'(CLK_DIV) - 1);
                if (p < int'(BLANK_CYCLES))
                    exp = {8'hFF, 7'h7F, 1'b1, t_exp};
                else
                    exp = {r.an_exp[8*s +: 8], r.seg_exp[8*s +: 7], r.dp_exp[s], t_exp};
                check($sformatf("frame%0d_d%0d_p%0d", idx, s, p), {an, seg, dp, frame_tick}, exp);
            end
        end
    endtask

    initial begin
        // 0: first frame after reset shows zeros; load 1234ABCD
        tbl[0]  = '{32'h1234ABCD, 8'h00, 1'b0, 1'b1, 8, 32'h0, 8, AN_NORM, SEG_ALL0, 8'hFF};
        // 1: normal scan of 1234ABCD; load A5 with leading-zero blanking
        tbl[1]  = '{32'h000000A5, 8'h00, 1'b1, 1'b1, 8, 32'h0, 8, AN_NORM,
                    64'h79243019_08034621, 8'hFF};
        // 2: A5 blanked above digit 1; load 0 with blanking
        tbl[2]  = '{32'h00000000, 8'h00, 1'b1, 1'b1, 8, 32'h0, 8, 64'hFFFFFFFF_FFFFFDFE,
                    64'h7F7F7F7F_7F7F0812, 8'hFF};
        // 3: value 0 with blanking shows a single 0; load 11111111
        tbl[3]  = '{32'h11111111, 8'h00, 1'b0, 1'b1, 8, 32'h0, 8, 64'hFFFFFFFF_FFFFFFFE,
                    64'h7F7F7F7F_7F7F7F40, 8'hFF};
        // 4: value changes to 22222222 at digit 3; frame must still show all 1s
        tbl[4]  = '{32'h11111111, 8'h00, 1'b0, 1'b1, 3, 32'h22222222, 8, AN_NORM, SEG_ALL1, 8'hFF};
        // 5: 2s appear only now; load dp mask 05
        tbl[5]  = '{32'h22222222, 8'h05, 1'b0, 1'b1, 8, 32'h0, 8, AN_NORM, SEG_ALL2, 8'hFF};
        // 6: enable low for a whole frame: dark, tick still pulses
        tbl[6]  = '{32'h22222222, 8'h05, 1'b0, 1'b0, 8, 32'h0, 8, AN_DARK, SEG_DARK, 8'hFF};
        // 7: enabled again, decimal points on digits 0 and 2
        tbl[7]  = '{32'h22222222, 8'h05, 1'b0, 1'b1, 8, 32'h0, 8, AN_NORM, SEG_ALL2, 8'hFA};
        // 8: aborted by reset when digit 5 is reached
        tbl[8]  = '{32'h33333333, 8'h00, 1'b0, 1'b1, 8, 32'h0, 5, AN_NORM, SEG_ALL2, 8'hFA};
        // 9: after mid-frame reset: zero snapshot; load 33333333
        tbl[9]  = '{32'h33333333, 8'h00, 1'b0, 1'b1, 8, 32'h0, 8, AN_NORM, SEG_ALL0, 8'hFF};
        // 10: 33333333 shown
        tbl[10] = '{32'h33333333, 8'h00, 1'b0, 1'b1, 8, 32'h0, 8, AN_NORM, SEG_ALL3, 8'hFF};

        // Reset asserted away from the clock edge; outputs dark at once.
        #1 clrn = 1'b0;
        #1 check("reset_async", {an, seg, dp, frame_tick}, {8'hFF, 7'h7F, 1'b1, 1'b0});
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("reset_hold%0d", i), {an, seg, dp, frame_tick}, {8'hFF, 7'h7F, 1'b1, 1'b0});
        end

        clrn = 1'b1;
        for (int f = 0; f <= 8; f++) run_frame(f);

        // Mid-frame reset while d = 5 (last output showed digit 4 lit).
        #3 clrn = 1'b0;
        #1 check("midreset_async", {an, seg, dp, frame_tick}, {8'hFF, 7'h7F, 1'b1, 1'b0});
        for (int i = 0; i < 2; i++) begin
            tick();
            check($sformatf("midreset_hold%0d", i), {an, seg, dp, frame_tick}, {8'hFF, 7'h7F, 1'b1, 1'b0});
        end
        clrn = 1'b1;
        run_frame(9);
        run_frame(10);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_seg7_scan_driver
